// File: rtl/load_store_unit_if.sv
// Request, memory-port and response bundle of the load/store stage.
// The slave view belongs to the unit; the master view belongs to its surroundings.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_funct3;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_funct3, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           rsp_valid, rsp_rdata, rsp_funct3, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: alignment check, word-addressed memory port with byte
// enables and lane-replicated store data, response with read data shifted to byte 0.
module load_store_unit #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  f3_q;
  logic [7:0]  cnt_q;
  logic [31:0] rsp_rdata_q;
  logic [2:0]  rsp_f3_q;
  logic        rsp_err_q;

  logic        legal, timeout_hit, in_access;
  logic [1:0]  off;
  logic [3:0]  be_w;
  logic [NUM_LANES-1:0][7:0] wd_lane;

  assign off       = addr_q[1:0];
  assign in_access = (state == ACCESS);
  // TIMEOUT==0 disables the watchdog; the counter then just wraps harmlessly.
  assign timeout_hit = (TIMEOUT != 8'd0) && (cnt_q == TIMEOUT - 8'd1);

  always_comb begin
    legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b100: legal = 1'b1;
      3'b001, 3'b101: legal = ~bus.req_addr[0];
      3'b010:         legal = (bus.req_addr[1:0] == 2'b00);
      default:        legal = 1'b0;
    endcase
    if (bus.req_we && bus.req_funct3[2]) legal = 1'b0;
  end

  always_comb begin
    be_w = 4'b1111;
    if (f3_q[1:0] == 2'b00)      be_w = 4'b0001 << off;
    else if (f3_q[1:0] == 2'b01) be_w = 4'b0011 << off;
  end

  // Each byte lane picks its source byte from the access width, replicating narrow stores.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wd_lane[l] = (f3_q[1:0] == 2'b10) ? wdata_q[8*l +: 8] :
                        f3_q[0]              ? wdata_q[8*(l%2) +: 8] :
                                               wdata_q[7:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = legal ? ACCESS : RESP;
      ACCESS:  if (bus.mem_ack || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_f3_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q    <= bus.req_we;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          f3_q    <= bus.req_funct3;
          cnt_q   <= '0;
          if (!legal) begin
            rsp_rdata_q <= '0;
            rsp_f3_q    <= bus.req_funct3;
            rsp_err_q   <= 1'b1;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 8'd1;
          if (bus.mem_ack) begin
            rsp_rdata_q <= we_q ? 32'd0 : (bus.mem_rdata >> {off, 3'b000});
            rsp_f3_q    <= f3_q;
            rsp_err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata_q <= '0;
            rsp_f3_q    <= f3_q;
            rsp_err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.mem_req    = in_access;
  assign bus.mem_we     = in_access & we_q;
  assign bus.mem_addr   = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.mem_be     = in_access ? be_w : 4'd0;
  assign bus.mem_wdata  = in_access ? wd_lane : 32'd0;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_funct3 = rsp_f3_q;
  assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a cycle-level reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_load_store_unit;
  localparam logic [7:0] TO = 8'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0, nerr = 0, cyc = 0;

  load_store_unit_if bus();
  load_store_unit #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic legal_of(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (we && f3 >= 3'd4) return 1'b0;
    return (a % size_of(f3)) == 0;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] b;
    int o, s;
    o = int'(a[1:0]);
    s = size_of(f3);
    for (int i = 0; i < 4; i++) b[i] = (i >= o) && (i < o + s);
    return b;
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int s;
    s = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'((d >> (8 * (i % s))) & 32'hFF);
    return w;
  endfunction

  localparam int M_IDLE = 0, M_ACC = 1, M_RESP = 2;
  int          m_st = M_IDLE, m_n = 0;
  logic        m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [2:0]  m_f3 = '0, m_rf3 = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= M_IDLE; m_n <= 0; m_rdata <= '0; m_rf3 <= '0; m_err <= 1'b0;
    end else begin
      case (m_st)
        M_IDLE: if (bus.req_valid) begin
          m_we <= bus.req_we; m_addr <= bus.req_addr; m_wdata <= bus.req_wdata;
          m_f3 <= bus.req_funct3; m_n <= 0;
          if (legal_of(bus.req_we, bus.req_funct3, bus.req_addr)) m_st <= M_ACC;
          else begin
            m_st <= M_RESP; m_rdata <= '0; m_err <= 1'b1; m_rf3 <= bus.req_funct3;
          end
        end
        M_ACC: begin
          if (bus.mem_ack) begin
            m_st <= M_RESP; m_err <= 1'b0; m_rf3 <= m_f3;
            m_rdata <= m_we ? 32'd0 : bus.mem_rdata / (32'd1 << (8 * int'(m_addr[1:0])));
          end else if (m_n + 1 == int'(TO)) begin
            m_st <= M_RESP; m_err <= 1'b1; m_rf3 <= m_f3; m_rdata <= '0;
          end else m_n <= m_n + 1;
        end
        default: m_st <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_be", bus.mem_be, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
    end else begin
      chk("m_req_ready", bus.req_ready, m_st == M_IDLE);
      chk("m_mem_req", bus.mem_req, m_st == M_ACC);
      if (m_st == M_ACC) begin
        chk("m_mem_we", bus.mem_we, m_we);
        chk("m_mem_addr", bus.mem_addr, m_addr & ~32'd3);
        chk("m_mem_be", bus.mem_be, be_of(m_f3, m_addr));
        if (m_we) chk("m_mem_wdata", bus.mem_wdata, wd_of(m_f3, m_wdata));
      end
      chk("m_rsp_valid", bus.rsp_valid, m_st == M_RESP);
      chk("m_rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("m_rsp_funct3", bus.rsp_funct3, m_rf3);
      chk("m_rsp_err", bus.rsp_err, m_err);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = d;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, done;
    int t_req[3];
    logic [2:0]  f3s[3];
    logic [31:0] adrs[3], exps[3];
    f3s  = '{3'b000, 3'b101, 3'b010};
    adrs = '{32'h7001, 32'h7002, 32'h7000};
    exps = '{32'h0011_2233, 32'h0000_1122, 32'h1122_3344};

    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_funct3 = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    repeat (2) tick();
    chk("reset_ready", bus.req_ready, 1);
    chk("reset_mem_req", bus.mem_req, 0);
    rst_n = 1'b1;
    tick();

    // lbu at byte 3, ack one cycle after mem_req rises
    issue(0, 3'b100, 32'h1003, 0);
    chk("t1_mem_req", bus.mem_req, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h1000);
    chk("t1_mem_be", bus.mem_be, 4'b1000);
    tick();
    bus.mem_ack = 1; bus.mem_rdata = 32'hAABBCCDD;
    tick();
    bus.mem_ack = 0;
    chk("t1_rsp_valid", bus.rsp_valid, 1);
    chk("t1_rsp_rdata", bus.rsp_rdata, 32'h0000_00AA);
    chk("t1_rsp_funct3", bus.rsp_funct3, 3'b100);
    chk("t1_rsp_err", bus.rsp_err, 0);
    tick();
    chk("t1_valid_drop", bus.rsp_valid, 0);
    chk("t1_rdata_hold", bus.rsp_rdata, 32'h0000_00AA);
    chk("t1_ready_back", bus.req_ready, 1);

    // sh at halfword 1
    issue(1, 3'b001, 32'h2002, 32'h12345678);
    chk("t2_mem_we", bus.mem_we, 1);
    chk("t2_mem_be", bus.mem_be, 4'b1100);
    chk("t2_mem_wdata", bus.mem_wdata, 32'h5678_5678);
    bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_ack = 0;
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    chk("t2_rsp_err", bus.rsp_err, 0);
    chk("t2_rsp_rdata", bus.rsp_rdata, 0);
    tick();

    // misaligned lw
    issue(0, 3'b010, 32'h3001, 0);
    chk("t3_mem_req", bus.mem_req, 0);
    chk("t3_rsp_valid", bus.rsp_valid, 1);
    chk("t3_rsp_err", bus.rsp_err, 1);
    chk("t3_ready_low", bus.req_ready, 0);
    tick();
    chk("t3_ready_back", bus.req_ready, 1);

    // store with unsigned width code and reserved funct3 are both illegal
    issue(1, 3'b100, 32'h3000, 0);
    chk("t3b_err", bus.rsp_err, 1);
    tick();
    issue(0, 3'b011, 32'h3000, 0);
    chk("t3c_err", bus.rsp_err, 1);
    chk("t3c_funct3", bus.rsp_funct3, 3'b011);
    tick();

    // sb at byte 1
    issue(1, 3'b000, 32'h5001, 32'h0000_00A5);
    chk("t3d_mem_be", bus.mem_be, 4'b0010);
    chk("t3d_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    tick();

    // timeout: no ack
    issue(0, 3'b010, 32'h4000, 0);
    hi = 0; done = 0;
    for (int k = 0; k < 12 && done == 0; k++) begin
      if (bus.rsp_valid) done = 1;
      else begin
        if (bus.mem_req) hi++;
        tick();
      end
    end
    chk("t4_rsp_seen", done, 1);
    chk("t4_req_cycles", hi, 4);
    chk("t4_rsp_err", bus.rsp_err, 1);
    chk("t4_rsp_rdata", bus.rsp_rdata, 0);
    tick();

    // ack arrives in the last allowed cycle: ack wins
    issue(0, 3'b010, 32'h4004, 0);
    repeat (3) tick();
    chk("t4b_req_still", bus.mem_req, 1);
    bus.mem_ack = 1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack = 0;
    chk("t4b_rsp_valid", bus.rsp_valid, 1);
    chk("t4b_rsp_err", bus.rsp_err, 0);
    chk("t4b_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    tick();

    // stray ack while idle is ignored
    bus.mem_ack = 1;
    tick();
    bus.mem_ack = 0;
    chk("t4c_no_rsp", bus.rsp_valid, 0);

    // reset mid-access
    issue(0, 3'b010, 32'h6000, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mem_req_async", bus.mem_req, 0);
    chk("t5_ready_in_reset", bus.req_ready, 1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5_ready_after", bus.req_ready, 1);
    chk("t5_no_rsp", bus.rsp_valid, 0);

    // back-to-back loads with req_valid held high
    bus.req_we = 0; bus.req_funct3 = f3s[0]; bus.req_addr = adrs[0]; bus.req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      int w;
      w = 0;
      while (!bus.mem_req && w < 10) begin tick(); w++; end
      chk("t6_req_seen", bus.mem_req, 1);
      t_req[i] = cyc;
      bus.mem_ack = 1; bus.mem_rdata = 32'h1122_3344;
      if (i < 2) begin bus.req_funct3 = f3s[i+1]; bus.req_addr = adrs[i+1]; end
      else bus.req_valid = 0;
      tick();
      bus.mem_ack = 0;
      chk("t6_rsp_valid", bus.rsp_valid, 1);
      chk("t6_rsp_funct3", bus.rsp_funct3, f3s[i]);
      chk("t6_rsp_rdata", bus.rsp_rdata, exps[i]);
    end
    chk("t6_gap01", t_req[1] - t_req[0], 3);
    chk("t6_gap12", t_req[2] - t_req[1], 3);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
